// File: rtl/configregpwm_merge_pkg.sv
// Shared PWM config types and the field merge/validate helper
// used by the config-register write path.
package PKG_pwm;

  localparam int PWMCOUNT_WIDTH = 16;
  localparam int CFG_FIELD_W = 5;

  localparam int SEL_COUNT = 0;
  localparam int SEL_MASK = 1;
  localparam int SEL_ONOFF = 2;

  typedef enum logic [1:0] {
    COUNT_UP = 2'd0,
    COUNT_DOWN = 2'd1,
    COUNT_UPDOWN = 2'd2,
    COUNT_RSVD = 2'd3
  } _count_mode;

  typedef enum logic [1:0] {
    MASK_NONE = 2'd0,
    MASK_A = 2'd1,
    MASK_B = 2'd2,
    MASK_AB = 2'd3
  } _mask_mode;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON = 1'b1
  } _pwm_onoff;

  typedef struct packed {
    _pwm_onoff pwm_onoff;
    _mask_mode mask_mode;
    _count_mode count_mode;
  } _pwm_cfg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PENDING = 2'd1,
    COMMIT = 2'd2
  } _cfgmerge_state;

  typedef struct packed {
    logic err;
    _pwm_cfg cfg;
  } _merge_res;

  // A rejected write leaves every field untouched.
  function automatic _merge_res cfg_merge(
    input _pwm_cfg cur,
    input logic [2:0] sel,
    input _count_mode cm,
    input _mask_mode mm,
    input _pwm_onoff oo
  );
    _merge_res r;
    r.err = sel[SEL_COUNT] && (cm == COUNT_RSVD);
    r.cfg = cur;
    if (!r.err) begin
      if (sel[SEL_COUNT]) r.cfg.count_mode = cm;
      if (sel[SEL_MASK]) r.cfg.mask_mode = mm;
      if (sel[SEL_ONOFF]) r.cfg.pwm_onoff = oo;
    end
    return r;
  endfunction

endpackage

// File: rtl/configregpwm_merge.sv
// Shadowed PWM config register: field writes merge into a shadow
// that commits on carrier sync; turn-off bypasses the shadow.
module configregpwm_merge
  import PKG_pwm::*;
#(
  parameter int REG_W = PWMCOUNT_WIDTH + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [2:0]       wr_sel,
  input  _count_mode       wr_count_mode,
  input  _mask_mode        wr_mask_mode,
  input  _pwm_onoff        wr_pwm_onoff,
  input  logic             sync_event,
  input  logic             force_update,
  input  logic             err_clr,
  output logic [REG_W-1:0] register_concat,
  output logic             pending,
  output logic             commit_pulse,
  output logic             err_sticky
);

  _cfgmerge_state state, state_next;
  _pwm_cfg active, active_next;
  _pwm_cfg shadow, shadow_next;
  _merge_res mr;
  logic accept;
  logic commit_req;
  logic safety_off;
  logic rdy_q;

  assign accept = wr_valid & rdy_q;
  assign commit_req = sync_event | force_update;
  assign mr = cfg_merge(shadow, wr_sel, wr_count_mode,
                        wr_mask_mode, wr_pwm_onoff);

  assign safety_off = accept & ~mr.err
                    & wr_sel[SEL_ONOFF]
                    & (wr_pwm_onoff == PWM_OFF);

  // Committing takes shadow_next so a same-cycle write is included.
  always_comb begin
    shadow_next = shadow;
    active_next = active;
    if (accept && !mr.err) shadow_next = mr.cfg;
    if (safety_off) active_next.pwm_onoff = PWM_OFF;
    if (state == PENDING && commit_req) active_next = shadow_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept && !mr.err && shadow_next != active_next)
          state_next = PENDING;
      end
      PENDING: begin
        if (commit_req) state_next = COMMIT;
        else if (shadow_next == active_next) state_next = IDLE;
      end
      COMMIT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pending = 1'b0;
    commit_pulse = 1'b0;
    unique case (1'b1)
      (state == PENDING): pending = 1'b1;
      (state == COMMIT): commit_pulse = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      active <= '0;
      shadow <= '0;
      rdy_q <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      active <= active_next;
      shadow <= shadow_next;
      rdy_q <= (state_next != COMMIT);
      err_sticky <= (accept & mr.err)
                  | (err_sticky & ~err_clr);
    end
  end

  assign wr_ready = rdy_q;
  assign register_concat = REG_W'(active);

endmodule

// File: tb/tb_configregpwm_merge.sv
// Bench for configregpwm_merge: directed table, reset corner
// cases, then random traffic against a field-level model.
module tb_configregpwm_merge;
  import PKG_pwm::*;

  localparam int REG_W = PWMCOUNT_WIDTH + 1;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic wr_valid = 1'b0;
  logic [2:0] wr_sel = '0;
  _count_mode wr_count_mode = COUNT_UP;
  _mask_mode wr_mask_mode = MASK_NONE;
  _pwm_onoff wr_pwm_onoff = PWM_OFF;
  logic sync_event = 1'b0;
  logic force_update = 1'b0;
  logic err_clr = 1'b0;
  logic wr_ready;
  logic [REG_W-1:0] register_concat;
  logic pending;
  logic commit_pulse;
  logic err_sticky;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  configregpwm_merge #(.REG_W(REG_W)) dut (
    .clk(clk),
    .rstn(rstn),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_sel(wr_sel),
    .wr_count_mode(wr_count_mode),
    .wr_mask_mode(wr_mask_mode),
    .wr_pwm_onoff(wr_pwm_onoff),
    .sync_event(sync_event),
    .force_update(force_update),
    .err_clr(err_clr),
    .register_concat(register_concat),
    .pending(pending),
    .commit_pulse(commit_pulse),
    .err_sticky(err_sticky)
  );

  // Reference model: active and shadow as plain field integers.
  int a_cnt, a_msk, a_on;
  int s_cnt, s_msk, s_on;
  bit m_err, m_commit, m_ready;

  function automatic int pack(int on, int msk, int cnt);
    return on * 16 + msk * 4 + cnt;
  endfunction

  task automatic model_reset();
    a_cnt = 0; a_msk = 0; a_on = 0;
    s_cnt = 0; s_msk = 0; s_on = 0;
    m_err = 0; m_commit = 0; m_ready = 0;
  endtask

  task automatic tick();
    int na_cnt, na_msk, na_on, ns_cnt, ns_msk, ns_on;
    bit was_pend, nerr, cm;
    na_cnt = a_cnt; na_msk = a_msk; na_on = a_on;
    ns_cnt = s_cnt; ns_msk = s_msk; ns_on = s_on;
    was_pend = pack(s_on, s_msk, s_cnt) != pack(a_on, a_msk, a_cnt);
    nerr = err_clr ? 1'b0 : m_err;
    if (wr_valid && m_ready) begin
      if (wr_sel[0] && int'(wr_count_mode) == 3) nerr = 1'b1;
      else begin
        if (wr_sel[0]) ns_cnt = int'(wr_count_mode);
        if (wr_sel[1]) ns_msk = int'(wr_mask_mode);
        if (wr_sel[2]) ns_on = int'(wr_pwm_onoff);
        if (wr_sel[2] && wr_pwm_onoff == PWM_OFF) na_on = 0;
      end
    end
    cm = was_pend && (sync_event || force_update);
    if (cm) begin
      na_cnt = ns_cnt; na_msk = ns_msk; na_on = ns_on;
    end
    @(posedge clk);
    if (!rstn) model_reset();
    else begin
      a_cnt = na_cnt; a_msk = na_msk; a_on = na_on;
      s_cnt = ns_cnt; s_msk = ns_msk; s_on = ns_on;
      m_err = nerr; m_commit = cm; m_ready = !cm;
    end
    #1;
  endtask

  task automatic cmp(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_model(string tag);
    cmp({tag, " reg"}, int'(register_concat), pack(a_on, a_msk, a_cnt));
    cmp({tag, " pending"}, int'(pending),
        int'(pack(s_on, s_msk, s_cnt) != pack(a_on, a_msk, a_cnt)));
    cmp({tag, " commit"}, int'(commit_pulse), int'(m_commit));
    cmp({tag, " err"}, int'(err_sticky), int'(m_err));
    cmp({tag, " ready"}, int'(wr_ready), int'(m_ready));
  endtask

  task automatic check_const(string tag, int r, int p, int c, int e, int y);
    cmp({tag, " reg"}, int'(register_concat), r);
    cmp({tag, " pending"}, int'(pending), p);
    cmp({tag, " commit"}, int'(commit_pulse), c);
    cmp({tag, " err"}, int'(err_sticky), e);
    cmp({tag, " ready"}, int'(wr_ready), y);
  endtask

  task automatic drive(bit v, logic [2:0] sel, int cm, int mm, int oo,
                       bit sy, bit fo, bit cl);
    wr_valid = v;
    wr_sel = sel;
    wr_count_mode = _count_mode'(cm[1:0]);
    wr_mask_mode = _mask_mode'(mm[1:0]);
    wr_pwm_onoff = _pwm_onoff'(oo[0]);
    sync_event = sy;
    force_update = fo;
    err_clr = cl;
  endtask

  typedef struct {
    bit v; logic [2:0] sel; int cm; int mm; int oo;
    bit sy; bit fo; bit cl;
    int e_reg; int e_p; int e_c; int e_e; int e_r;
  } vec_t;

  function automatic vec_t mk(bit v, logic [2:0] sel, int cm, int mm,
                              int oo, bit sy, bit fo, bit cl, int r,
                              int p, int c, int e, int y);
    vec_t t;
    t.v = v; t.sel = sel; t.cm = cm; t.mm = mm; t.oo = oo;
    t.sy = sy; t.fo = fo; t.cl = cl;
    t.e_reg = r; t.e_p = p; t.e_c = c; t.e_e = e; t.e_r = y;
    return t;
  endfunction

  vec_t tbl[21];

  initial begin
    //          v sel    cm mm oo sy fo cl  reg p c e r
    tbl[0]  = mk(1, 3'b001, 2, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1);
    tbl[1]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 1);
    tbl[2]  = mk(0, 3'b000, 0, 0, 0, 1, 0, 0,  2, 0, 1, 0, 0);
    tbl[3]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,  2, 0, 0, 0, 1);
    tbl[4]  = mk(1, 3'b110, 0, 1, 1, 0, 0, 0,  2, 1, 0, 0, 1);
    tbl[5]  = mk(0, 3'b000, 0, 0, 0, 0, 1, 0, 22, 0, 1, 0, 0);
    tbl[6]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 22, 0, 0, 0, 1);
    tbl[7]  = mk(1, 3'b110, 0, 2, 0, 0, 0, 0,  6, 1, 0, 0, 1);
    tbl[8]  = mk(0, 3'b000, 0, 0, 0, 1, 0, 0, 10, 0, 1, 0, 0);
    tbl[9]  = mk(0, 3'b000, 0, 0, 0, 0, 0, 0, 10, 0, 0, 0, 1);
    tbl[10] = mk(1, 3'b011, 3, 3, 0, 0, 0, 0, 10, 0, 0, 1, 1);
    tbl[11] = mk(0, 3'b000, 0, 0, 0, 0, 0, 1, 10, 0, 0, 0, 1);
    tbl[12] = mk(1, 3'b010, 0, 1, 0, 0, 0, 0, 10, 1, 0, 0, 1);
    tbl[13] = mk(1, 3'b001, 1, 0, 0, 1, 0, 0,  5, 0, 1, 0, 0);
    tbl[14] = mk(0, 3'b000, 0, 0, 0, 0, 0, 0,  5, 0, 0, 0, 1);
    tbl[15] = mk(1, 3'b001, 3, 0, 0, 0, 0, 1,  5, 0, 0, 1, 1);
    tbl[16] = mk(0, 3'b000, 0, 0, 0, 0, 0, 1,  5, 0, 0, 0, 1);
    tbl[17] = mk(1, 3'b000, 2, 3, 1, 0, 0, 0,  5, 0, 0, 0, 1);
    tbl[18] = mk(0, 3'b000, 0, 0, 0, 1, 0, 0,  5, 0, 0, 0, 1);
    tbl[19] = mk(1, 3'b100, 0, 0, 1, 0, 0, 0,  5, 1, 0, 0, 1);
    tbl[20] = mk(1, 3'b100, 0, 0, 0, 0, 0, 0,  5, 0, 0, 0, 1);

    model_reset();
    #1 rstn = 1'b0;
    #2 check_const("in_reset", 0, 0, 0, 0, 0);
    #9 rstn = 1'b1;
    repeat (5) tick();
    check_const("post_reset", 0, 0, 0, 0, 1);

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].v, tbl[i].sel, tbl[i].cm, tbl[i].mm, tbl[i].oo,
            tbl[i].sy, tbl[i].fo, tbl[i].cl);
      tick();
      check_const($sformatf("vec%0d", i), tbl[i].e_reg, tbl[i].e_p,
                  tbl[i].e_c, tbl[i].e_e, tbl[i].e_r);
    end

    // Write refused while committing, then reset mid-commit.
    drive(1, 3'b001, 2, 0, 0, 0, 0, 0);
    tick();
    drive(0, 3'b000, 0, 0, 0, 0, 1, 0);
    tick();
    check_const("force_commit", 6, 0, 1, 0, 0);
    drive(1, 3'b010, 0, 3, 0, 0, 0, 0);
    tick();
    check_const("commit_refuse", 6, 0, 0, 0, 1);
    drive(1, 3'b001, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 3'b000, 0, 0, 0, 0, 1, 0);
    tick();
    check_const("commit2", 4, 0, 1, 0, 0);
    drive(0, 3'b000, 0, 0, 0, 0, 0, 0);
    rstn = 1'b0;
    #2 check_const("async_reset", 0, 0, 0, 0, 0);
    model_reset();
    #8 rstn = 1'b1;
    tick();
    check_const("after_reset", 0, 0, 0, 0, 1);
    drive(0, 3'b000, 0, 0, 0, 1, 0, 0);
    tick();
    check_const("shadow_lost", 0, 0, 0, 0, 1);

    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            int'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
            $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/configregpwm_merge.md
Name: configregpwm_merge

Overview:
- Write-side counterpart of the PWM config-register field split. Accepts field-granular writes from the control plane (PS/AXI glue) into a shadow register.
- Commits the shadow to the active concatenated config register only on a PWM carrier sync event or a forced update, so mode changes never tear a carrier period.
- Turn-off requests are applied immediately as a safety path.
- `register_concat` feeds the field-split block and the PWM core.

Parameters:
- REG_W, default `PWMCOUNT_WIDTH+1: width of `register_concat`. Must be ≥5; bits REG_W-1:5 are reserved and always 0.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- wr_valid  in  1  field-write request
- wr_ready  out  1  write accepted when wr_valid&wr_ready at rising clk
- wr_sel  in  3  field enables: [0]=count_mode, [1]=mask_mode, [2]=pwm_onoff
- wr_count_mode  in  _count_mode (2)  new count mode
- wr_mask_mode  in  _mask_mode (2)  new mask mode
- wr_pwm_onoff  in  _pwm_onoff (1)  new on/off
- sync_event  in  1  one-cycle pulse at carrier period boundary
- force_update  in  1  commit pending shadow at next edge, ignoring sync
- err_clr  in  1  clears err_sticky
- register_concat  out  REG_W  active config: [1:0] count_mode, [3:2] mask_mode, [4] pwm_onoff, rest 0
- pending  out  1  shadow differs from active (uncommitted write exists)
- commit_pulse  out  1  high for exactly the cycle after active was updated from shadow
- err_sticky  out  1  an invalid write was rejected

Behaviour:
- Reset (rstn=0, async): shadow=active=0 (COUNT_UP, MASK_NONE, PWM_OFF); register_concat=0, pending=0, commit_pulse=0, err_sticky=0; state IDLE. wr_ready=1 from the first cycle after rstn rises. Reset mid-commit discards shadow.
- FSM states:
  - IDLE: wr_ready=1. Accepted valid write → shadow merged per wr_sel → PENDING. A write whose merged shadow equals active stays IDLE.
  - PENDING: wr_ready=1, pending=1. Further writes merge into shadow. On (sync_event | force_update), active ← shadow_next at that edge, where shadow_next includes any write accepted in the same cycle → COMMIT.
  - COMMIT: one cycle. wr_ready=0, commit_pulse=1, pending=0 → IDLE.
- Merge rule: only fields with wr_sel bit set are updated. wr_sel=0 with wr_valid is accepted as a no-op.
- Invalid write: wr_sel[0]=1 and wr_count_mode=2'b11 (reserved).
  - Handshake completes, whole write is discarded (no field updated), err_sticky←1.
  - err_sticky holds until err_clr; err_clr and a new error in the same cycle leave it at 1.
- Safety off: an accepted valid write with wr_sel[2]=1 and wr_pwm_onoff=PWM_OFF sets active.pwm_onoff and shadow.pwm_onoff to OFF at that same edge, in any state. Other fields in that write follow the normal pending path. Turn-on is only ever applied through commit.
- sync_event or force_update in IDLE or COMMIT: no effect.
- Latency:
  - Accepted write → pending=1 the next cycle.
  - sync edge → register_concat updated at that edge and visible the next cycle, with commit_pulse in that same cycle.
- All outputs are registered; no combinational path from inputs to register_concat.

Decomposition:
- Shared package PKG_pwm: typedefs _count_mode, _mask_mode, _pwm_onoff; new packed struct _pwm_cfg {pwm_onoff, mask_mode, count_mode} matching bit layout [4:0]; enum _cfgmerge_state {IDLE, PENDING, COMMIT}; localparam CFG_FIELD_W=5; field-select bit indices.
- No sub-module needed. The merge/validate function (shadow, wr_sel, wr fields → next shadow, err) is a package function shared with the bench's reference model.

Test Plan:
- Reset then idle 5 cycles → register_concat=0, pending=0, wr_ready=1, err_sticky=0.
- Write sel=3'b001 count_mode=2 (UPDOWN), no sync 10 cycles → register_concat unchanged (0), pending=1. Pulse sync_event → next cycle register_concat[1:0]=2, commit_pulse=1 for 1 cycle, wr_ready=0 in that cycle, pending=0.
- Active onoff=ON, mask=1. Write sel=3'b110 mask=2 onoff=OFF → next cycle register_concat[4]=0 immediately, [3:2] still 1. After sync → [3:2]=2.
- Write count_mode=3 sel=3'b011 mask=3 → no field change, pending stays 0, err_sticky=1. Pulse err_clr → err_sticky=0.
- Write sel=3'b001 count_mode=1 in the same cycle as sync_event while PENDING with mask=2 → active gets count=1 and mask=2 together; single commit_pulse.
- force_update with pending=1 and no sync → commit the next edge. Assert rstn low during COMMIT → all outputs 0 asynchronously; shadow is lost after release.
